// File: rtl/crypt_if.sv
// Bundle between the cipher engine, its controller and the single-port RAM.
// start is a one-cycle request honoured only while busy and done are both low;
// mem_rdata returns the word at mem_addr one cycle after it is presented.
interface crypt_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              start;
  logic              mode;
  logic [DATA_W-1:0] key;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   max_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;

  modport master (
    output start, mode, key, base_addr, max_len, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, done, count
  );

  modport slave (
    input  start, mode, key, base_addr, max_len, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, done, count
  );
endinterface

// File: rtl/crypt_engine.sv
// In-place memory cipher: walks RAM from a base address, rotating/XORing each
// element with a key until a terminator word or the length limit is reached.
module crypt_engine #(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 8,
  parameter logic [DATA_W-1:0] TERM   = '0
) (
  input  logic       clock,
  input  logic       reset,
  crypt_if.slave     bus,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_LAT  = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        state, state_nx;
  logic [ADDR_W:0]   idx, max_len_q, count_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] elem, key_q, mixed, enc_val, dec_val, xform;
  logic              mode_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_RD;
      S_RD:    state_nx = (idx == max_len_q) ? S_DONE : S_LAT;
      S_LAT:   state_nx = S_CHK;
      // The terminator test uses the raw RAM word in both directions.
      S_CHK:   state_nx = (elem == TERM) ? S_DONE : S_WR;
      S_WR:    state_nx = S_RD;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      max_len_q <= '0;
      count_q   <= '0;
      base_q    <= '0;
      elem      <= '0;
      key_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          mode_q    <= bus.mode;
          key_q     <= bus.key;
          base_q    <= bus.base_addr;
          max_len_q <= bus.max_len;
          idx       <= '0;
          count_q   <= '0;
        end
        S_LAT: elem <= bus.mem_rdata;
        S_WR: begin
          idx     <= idx + 1'b1;
          count_q <= count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Encrypt rotates after the XOR; decrypt undoes it in reverse order.
  always_comb begin
    mixed   = elem ^ key_q;
    enc_val = {mixed[DATA_W-2:0], mixed[DATA_W-1]};
    dec_val = {elem[0], elem[DATA_W-1:1]} ^ key_q;
    xform   = mode_q ? dec_val : enc_val;
  end

  always_comb begin
    bus.mem_addr  = base_q + idx[ADDR_W-1:0];
    bus.mem_we    = (state == S_WR);
    bus.mem_wdata = (state == S_WR) ? xform : '0;
    bus.busy      = (state == S_RD) || (state == S_LAT) ||
                    (state == S_CHK) || (state == S_WR);
    bus.done      = (state == S_DONE);
    bus.count     = count_q;
    state_dbg     = state;
  end

endmodule

// File: tb/tb_crypt_engine.sv
// Bench for crypt_engine: directed and randomized passes over an 8-bit RAM
// checked against an array model, plus a 16-bit instance for width coverage.
module tb_crypt_engine;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  crypt_if #(.DATA_W(8),  .ADDR_W(8)) bus8();
  crypt_if #(.DATA_W(16), .ADDR_W(4)) bus16();
  logic [2:0] st8, st16;

  crypt_engine #(.DATA_W(8), .ADDR_W(8), .TERM(8'h00)) dut8 (
    .clock(clock), .reset(reset), .bus(bus8), .state_dbg(st8));
  crypt_engine #(.DATA_W(16), .ADDR_W(4), .TERM(16'h0000)) dut16 (
    .clock(clock), .reset(reset), .bus(bus16), .state_dbg(st16));

  // RAM models; the bench preloads words through a side port while idle.
  logic [7:0]  ram8[256];
  logic [15:0] ram16[16];
  logic        tb_we8, tb_we16;
  logic [7:0]  tb_a8, tb_d8;
  logic [3:0]  tb_a16;
  logic [15:0] tb_d16;

  always @(posedge clock) begin
    if (bus8.mem_we) ram8[bus8.mem_addr] <= bus8.mem_wdata;
    else if (tb_we8) ram8[tb_a8] <= tb_d8;
    bus8.mem_rdata <= ram8[bus8.mem_addr];
  end

  always @(posedge clock) begin
    if (bus16.mem_we) ram16[bus16.mem_addr] <= bus16.mem_wdata;
    else if (tb_we16) ram16[tb_a16] <= tb_d16;
    bus16.mem_rdata <= ram16[bus16.mem_addr];
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference transform from the rotate/XOR rules, written as arithmetic.
  function automatic int xf(input int w, input bit m, input int k, input int x);
    int md, v;
    md = 1 << w;
    if (!m) begin
      v = x ^ k;
      return (v * 2) % md + v / (md / 2);
    end
    return ((x / 2) + (x % 2) * (md / 2)) ^ k;
  endfunction

  task automatic put8(input int a, input int d);
    tb_we8 = 1'b1; tb_a8 = 8'(a); tb_d8 = 8'(d);
    @(posedge clock); #1;
    tb_we8 = 1'b0;
  endtask

  task automatic put16(input int a, input int d);
    tb_we16 = 1'b1; tb_a16 = 4'(a); tb_d16 = 16'(d);
    @(posedge clock); #1;
    tb_we16 = 1'b0;
  endtask

  // One 8-bit pass: model, drive, time the done pulse, then compare RAM.
  task automatic run8(input string tag, input bit m, input int k, input int b,
                      input int ml, input bit disturb);
    logic [7:0] mdl[256];
    int exp_cnt, exp_done, n, we_seen, a;
    bit busy_ok, got_done;
    for (int i = 0; i < 256; i++) mdl[i] = ram8[i];
    exp_cnt = 0;
    for (int j = 0; j < ml; j++) begin
      a = (b + j) % 256;
      if (mdl[a] == 8'h00) break;
      mdl[a] = 8'(xf(8, m, k, int'(mdl[a])));
      exp_cnt++;
    end
    exp_done = (exp_cnt < ml) ? 4 * exp_cnt + 4 : 4 * exp_cnt + 2;
    for (int j = 0; j <= ml; j++) exp_q.push_back(mdl[(b + j) % 256]);

    bus8.mode = m; bus8.key = 8'(k); bus8.base_addr = 8'(b);
    bus8.max_len = 9'(ml); bus8.start = 1'b1;
    @(posedge clock); #1;
    bus8.start = 1'b0;
    n = 1; busy_ok = 1'b1; we_seen = 0; got_done = 1'b0;
    while (n <= exp_done + 8) begin
      if (bus8.done) begin got_done = 1'b1; break; end
      if (!bus8.busy) busy_ok = 1'b0;
      if (bus8.mem_we) we_seen++;
      if (disturb) begin
        bus8.key = 8'($urandom); bus8.mode = 1'($urandom);
        bus8.base_addr = 8'($urandom); bus8.max_len = 9'($urandom);
        bus8.start = (n == 3);
      end
      @(posedge clock); #1;
      n++;
    end
    bus8.start = 1'b0;
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_done_cycle"}, 32'(n), 32'(exp_done));
    check({tag, "_count"}, 32'(bus8.count), 32'(exp_cnt));
    check({tag, "_busy_span"}, 32'(busy_ok), 32'd1);
    check({tag, "_writes"}, 32'(we_seen), 32'(exp_cnt));
    @(posedge clock); #1;
    check({tag, "_done_pulse"}, 32'(bus8.done), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus8.busy), 32'd0);
    for (int j = 0; j <= ml; j++)
      check($sformatf("%s_ram%0d", tag, j), 32'(ram8[(b + j) % 256]), 32'(exp_q.pop_front()));
  endtask

  task automatic run16(input string tag, input bit m, input int k);
    int n;
    bit got_done;
    bus16.mode = m; bus16.key = 16'(k); bus16.base_addr = 4'd0;
    bus16.max_len = 5'd8; bus16.start = 1'b1;
    @(posedge clock); #1;
    bus16.start = 1'b0;
    got_done = 1'b0;
    for (n = 1; n <= 40; n++) begin
      if (bus16.done) begin got_done = 1'b1; break; end
      @(posedge clock); #1;
    end
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_done_cycle"}, 32'(n), 32'd8);
    check({tag, "_count"}, 32'(bus16.count), 32'd1);
    @(posedge clock); #1;
  endtask

  int rb, rml, n;
  bit saw_done;

  initial begin
    tb_we8 = 1'b0; tb_a8 = '0; tb_d8 = '0;
    tb_we16 = 1'b0; tb_a16 = '0; tb_d16 = '0;
    bus8.start = 1'b0; bus8.mode = 1'b0; bus8.key = '0; bus8.base_addr = '0; bus8.max_len = '0;
    bus16.start = 1'b0; bus16.mode = 1'b0; bus16.key = '0; bus16.base_addr = '0; bus16.max_len = '0;
    for (int i = 0; i < 256; i++) ram8[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 16; i++) ram16[i] = 16'hFFFF;
    repeat (3) @(posedge clock);
    #1;
    check("rst_we", 32'(bus8.mem_we), 32'd0);
    check("rst_addr", 32'(bus8.mem_addr), 32'd0);
    check("rst_wdata", 32'(bus8.mem_wdata), 32'd0);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_count", 32'(bus8.count), 32'd0);
    check("rst_state", 32'(st8), 32'd0);
    check("rst_state16", 32'(st16), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    put8(0, 'h31); put8(1, 'h42); put8(2, 'h00);
    run8("enc_term", 1'b0, 'h5A, 0, 10, 1'b0);
    check("enc_ram0", 32'(ram8[0]), 32'hD6);
    check("enc_ram1", 32'(ram8[1]), 32'h30);
    run8("dec_rt", 1'b1, 'h5A, 0, 10, 1'b0);
    check("dec_ram0", 32'(ram8[0]), 32'h31);
    check("dec_ram1", 32'(ram8[1]), 32'h42);

    put8(0, 'h01); put8(1, 'h02); put8(2, 'h03); put8(3, 'h04);
    run8("cap", 1'b0, 'h5A, 0, 2, 1'b0);
    check("cap_ram0", 32'(ram8[0]), 32'hB6);
    check("cap_ram1", 32'(ram8[1]), 32'hB0);
    check("cap_ram2", 32'(ram8[2]), 32'h03);

    put8('hFE, 'h11); put8('hFF, 'h22); put8(0, 'h00);
    run8("wrap", 1'b0, 'h5A, 'hFE, 10, 1'b0);
    run8("zero_len", 1'b0, 'h5A, 5, 0, 1'b0);

    for (int i = 0; i < 6; i++) put8(16 + i, 'h10 + i);
    put8(22, 'h00);
    run8("busy_start", 1'b0, 'h3C, 16, 10, 1'b1);

    for (int it = 0; it < 10; it++) begin
      rb = $urandom_range(0, 255);
      rml = $urandom_range(0, 12);
      for (int j = 0; j < 14; j++)
        put8((rb + j) % 256, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255));
      run8($sformatf("rnd%0d", it), 1'($urandom), $urandom_range(0, 255), rb, rml, 1'($urandom));
    end

    // Reset lands in the WR cycle of element 1.
    put8(0, 'h10); put8(1, 'h20); put8(2, 'h30); put8(3, 'h00);
    bus8.mode = 1'b0; bus8.key = 8'h5A; bus8.base_addr = 8'd0; bus8.max_len = 9'd10;
    bus8.start = 1'b1;
    @(posedge clock); #1;
    bus8.start = 1'b0;
    repeat (7) begin @(posedge clock); #1; end
    check("mid_we_before", 32'(bus8.mem_we), 32'd1);
    check("mid_addr_before", 32'(bus8.mem_addr), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_we_async", 32'(bus8.mem_we), 32'd0);
    check("mid_state", 32'(st8), 32'd0);
    check("mid_count", 32'(bus8.count), 32'd0);
    check("mid_busy", 32'(bus8.busy), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_ram0", 32'(ram8[0]), 32'(xf(8, 1'b0, 'h5A, 'h10)));
    check("mid_ram1", 32'(ram8[1]), 32'h20);
    saw_done = 1'b0;
    for (n = 0; n < 8; n++) begin
      if (bus8.done) saw_done = 1'b1;
      @(posedge clock); #1;
    end
    check("mid_no_done", 32'(saw_done), 32'd0);

    put16(0, 'h1234); put16(1, 'h0000);
    run16("w16_enc", 1'b0, 'hA5A5);
    check("w16_enc_ram0", 32'(ram16[0]), 32'h6F23);
    check("w16_enc_ram1", 32'(ram16[1]), 32'h0000);
    run16("w16_dec", 1'b1, 'hA5A5);
    check("w16_dec_ram0", 32'(ram16[0]), 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
